// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind uart_rx.
// Each received word is captured together with its 2-bit error status and held in a circular FIFO.
// The host side reads it through a first-word-fall-through valid/ready port.
// The block also reports fill level, threshold and sticky overflow status.
// Optional macro RX_TIMEOUT_EN adds a character-timeout counter clocked by i_baud_x16.
// Without that macro, o_timeout is tied to 0.
//
// Handshake: o_valid means the head entry (o_dout/o_dout_error) is meaningful. A word leaves
// the FIFO on every rising edge where o_valid && i_ready. o_valid never depends on i_ready.
// The producer side has no back-pressure: i_din_valid is a one-cycle strobe. A strobe that
// arrives while the FIFO is full and no word is leaving on the same edge is dropped, and
// that drop is latched in o_overflow.
module uart_rx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int THRESH        = 8,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_WIDTH-1:0]    i_din,
  input  logic                     i_din_valid,
  input  logic [1:0]               i_din_error,
  input  logic                     i_baud_x16,
  output logic [DATA_WIDTH-1:0]    o_dout,
  output logic [1:0]               o_dout_error,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_thresh,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf,
  output logic                     o_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Status comes straight from the registered count, so it needs no extra cycle of latency.
  assign o_count  = count;
  assign o_empty  = (count == '0);
  assign o_full   = (count == CW'(DEPTH));
  assign o_thresh = (count >= CW'(THRESH));
  assign o_valid  = !o_empty;

  // A full FIFO still accepts a word if the head is leaving on the same edge.
  assign pop  = o_valid && i_ready;
  assign push = i_din_valid && (!o_full || pop);

  // The head is read combinationally; the outputs are masked so nothing stale shows when empty.
  assign head         = mem[rd_ptr];
  assign o_dout       = o_valid ? head[DATA_WIDTH-1:0] : '0;
  assign o_dout_error = o_valid ? head[EW-1:DATA_WIDTH] : 2'b00;

  // Storage write; the array is deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr] <= {i_din_error, i_din};
    end
  end

  // Pointers and fill level; the pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Sticky overflow; a new drop wins over a clear requested in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
    end else if (i_din_valid && o_full && !pop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_cnt;

  // Idle-time counter: it counts baud ticks while data waits unread and restarts on any traffic.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (push || pop || o_empty) begin
      tmo_cnt <= '0;
    end else if (i_baud_x16 && (tmo_cnt != TW'(TIMEOUT_TICKS))) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign o_timeout = (tmo_cnt == TW'(TIMEOUT_TICKS));
`else
  logic unused_baud;
  assign unused_baud = i_baud_x16;
  assign o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16, THRESH=8, TIMEOUT_TICKS=640).
// Timeout steps are compiled in only when RX_TIMEOUT_EN is defined.
module tb_uart_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_din;
  logic       i_din_valid;
  logic [1:0] i_din_error;
  logic       i_baud_x16;
  logic [7:0] o_dout;
  logic [1:0] o_dout_error;
  logic       o_valid;
  logic       i_ready;
  logic [4:0] o_count;
  logic       o_empty;
  logic       o_full;
  logic       o_thresh;
  logic       o_overflow;
  logic       i_clr_ovf;
  logic       o_timeout;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  uart_rx_fifo #(
    .DATA_WIDTH(8), .DEPTH(16), .THRESH(8), .TIMEOUT_TICKS(640)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_din(i_din), .i_din_valid(i_din_valid),
    .i_din_error(i_din_error), .i_baud_x16(i_baud_x16), .o_dout(o_dout),
    .o_dout_error(o_dout_error), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full), .o_thresh(o_thresh),
    .o_overflow(o_overflow), .i_clr_ovf(i_clr_ovf), .o_timeout(o_timeout)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic push(input logic [7:0] d, input logic [1:0] e);
    i_din = d; i_din_error = e; i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    exp_q.push_back({e, d});
  endtask

  // scoreboard: compare the head with the oldest expected entry, then pop it
  task automatic pop_check(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s observed pop expected no-entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_data"}, 32'(o_dout), 32'(e[7:0]));
      chk({tag, "_err"}, 32'(o_dout_error), 32'(e[9:8]));
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end
  endtask

  task automatic baud_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_baud_x16 = 1'b1;
      tick();
      i_baud_x16 = 1'b0;
    end
  endtask

  initial begin
    i_rst = 1'b1; i_din = '0; i_din_valid = 1'b0; i_din_error = '0;
    i_baud_x16 = 1'b0; i_ready = 1'b0; i_clr_ovf = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // reset state
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_dout", 32'(o_dout), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    chk("rst_thresh", 32'(o_thresh), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);

    // three words in, then drained in order
    push(8'hA6, 2'b00);
    chk("ffwt_valid", 32'(o_valid), 32'd1);
    chk("ffwt_dout", 32'(o_dout), 32'hA6);
    push(8'h37, 2'b01);
    push(8'h00, 2'b00);
    chk("three_count", 32'(o_count), 32'd3);
    chk("three_head", 32'(o_dout), 32'hA6);
    pop_check("p0");
    pop_check("p1");
    pop_check("p2");
    chk("three_empty", 32'(o_empty), 32'd1);
    chk("three_dout0", 32'(o_dout), 32'd0);

    // threshold
    for (int i = 0; i < 7; i++) push(8'(8'h10 + i), 2'(i));
    chk("th7_count", 32'(o_count), 32'd7);
    chk("th7_thresh", 32'(o_thresh), 32'd0);
    push(8'h17, 2'b11);
    chk("th8_count", 32'(o_count), 32'd8);
    chk("th8_thresh", 32'(o_thresh), 32'd1);
    pop_check("th_pop");
    chk("th_pop_count", 32'(o_count), 32'd7);
    chk("th_pop_thresh", 32'(o_thresh), 32'd0);
    while (exp_q.size() != 0) pop_check("th_drain");
    chk("th_empty", 32'(o_empty), 32'd1);

    // full and overflow
    for (int i = 0; i < 16; i++) push(8'(8'h80 + 3 * i), 2'(i + 1));
    chk("full_flag", 32'(o_full), 32'd1);
    chk("full_count", 32'(o_count), 32'd16);
    chk("full_ovf0", 32'(o_overflow), 32'd0);
    i_din = 8'hFF; i_din_error = 2'b11; i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_count", 32'(o_count), 32'd16);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    // a drop in the same cycle as a clear must still latch
    i_din = 8'hFF; i_din_valid = 1'b1; i_clr_ovf = 1'b1;
    tick();
    i_din_valid = 1'b0; i_clr_ovf = 1'b0;
    chk("ovf_prio", 32'(o_overflow), 32'd1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("ovf_clr2", 32'(o_overflow), 32'd0);
    // full: push and pop on the same edge
    chk("fpp_head", 32'(o_dout), 32'h80);
    i_din = 8'h55; i_din_error = 2'b10; i_din_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_din_valid = 1'b0; i_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back({2'b10, 8'h55});
    chk("fpp_count", 32'(o_count), 32'd16);
    chk("fpp_ovf", 32'(o_overflow), 32'd0);
    chk("fpp_next", 32'(o_dout), 32'h83);
    while (exp_q.size() > 1) pop_check("full_drain");
    chk("last_is_55", 32'(o_dout), 32'h55);
    pop_check("full_last");
    chk("full_empty", 32'(o_empty), 32'd1);

    // pointer wrap with interleaved pops
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h20 + 5 * i), 2'(i));
      if (i % 3 == 2) pop_check("wrap_pop");
    end
    chk("wrap_count", 32'(o_count), 32'd14);
    while (exp_q.size() != 0) pop_check("wrap_drain");
    chk("wrap_empty", 32'(o_empty), 32'd1);

    // reset mid-stream beats a same-cycle push and pop
    push(8'hC1, 2'b01);
    push(8'hC2, 2'b10);
    i_din = 8'hC3; i_din_valid = 1'b1; i_ready = 1'b1; i_rst = 1'b1;
    tick();
    i_din_valid = 1'b0; i_ready = 1'b0; i_rst = 1'b0;
    exp_q.delete();
    chk("mrst_count", 32'(o_count), 32'd0);
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_dout", 32'(o_dout), 32'd0);
    push(8'h3C, 2'b01);
    pop_check("post_rst");

`ifdef RX_TIMEOUT_EN
    push(8'h99, 2'b00);
    baud_ticks(639);
    chk("tmo_639", 32'(o_timeout), 32'd0);
    baud_ticks(1);
    chk("tmo_640", 32'(o_timeout), 32'd1);
    baud_ticks(5);
    chk("tmo_sat", 32'(o_timeout), 32'd1);
    pop_check("tmo_pop");
    chk("tmo_pop_clr", 32'(o_timeout), 32'd0);
    push(8'h9A, 2'b00);
    baud_ticks(639);
    push(8'h9B, 2'b01);
    baud_ticks(1);
    chk("tmo_push_clr", 32'(o_timeout), 32'd0);
    while (exp_q.size() != 0) pop_check("tmo_drain");
`else
    push(8'h99, 2'b00);
    baud_ticks(700);
    chk("tmo_off", 32'(o_timeout), 32'd0);
    pop_check("tmo_off_pop");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
